program_loader: RTL

Front-end loader that sits directly upstream of the single-cycle RISC core. It takes a framed 16-bit word stream over a valid/ready handshake and drives the core's external instruction-memory and data-memory write ports. It holds the core in test mode while loading. On a RUN command it releases the core, sequences its clear, waits for halt, then returns to loading.

---
 rtl/program_loader.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed stream loader and run sequencer for the single-cycle RISC core
//
// Accepts header/address/data frames over a valid/ready stream and turns data
// words into registered instruction- or data-memory writes. A RUN header
// releases the core from test mode, holds its clear for CLR_CYCLES cycles,
// then waits for the core to report halt before returning to loading.

module program_loader #(
  parameter int CLR_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        clr_i,

  input  logic        in_valid_i,
  input  logic [15:0] in_data_i,
  output logic        in_ready_o,

  input  logic        cpu_done_i,
  output logic        test_normal_o,
  output logic        cpu_clr_o,

  output logic        ext_instr_we_o,
  output logic [15:0] ext_instr_addr_o,
  output logic [15:0] ext_instr_data_o,

  output logic        ext_data_we_o,
  output logic [15:0] ext_data_addr_o,
  output logic [15:0] ext_data_data_o,

  output logic        busy_o,
  output logic        run_done_o,
  output logic        err_o
);

  // Header type field encodings.
  localparam logic [1:0] HDR_INSTR = 2'b00;
  localparam logic [1:0] HDR_DATA  = 2'b01;
  localparam logic [1:0] HDR_RUN   = 2'b10;

  // Width of the clear-hold counter; it counts CLR_CYCLES-1 down to zero.
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REL  = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e        state_q, state_d;

  // Frame context: remaining word count, next write address, and target memory.
  logic [13:0]   count_q, count_d;
  logic [15:0]   addr_q, addr_d;
  logic          is_data_q, is_data_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;

  // Registered write ports and run-complete pulse.
  logic          instr_we_q, instr_we_d;
  logic [15:0]   instr_addr_q, instr_addr_d;
  logic [15:0]   instr_data_q, instr_data_d;
  logic          data_we_q, data_we_d;
  logic [15:0]   data_addr_q, data_addr_d;
  logic [15:0]   data_data_q, data_data_d;
  logic          run_done_q, run_done_d;

  logic          accept;
  logic [1:0]    hdr_type;

  assign hdr_type = in_data_i[15:14];
  assign accept   = in_valid_i & in_ready_o;

  // State register; clr drops any frame in progress back to IDLE.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: frame parsing, clear hold and halt wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (hdr_type)
            HDR_INSTR, HDR_DATA: state_d = S_ADDR;
            HDR_RUN:             state_d = S_REL;
            default:             state_d = S_ERR;
          endcase
        end
      end
      S_ADDR: begin
        if (accept) begin
          state_d = (count_q == 14'd0) ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (accept && count_q == 14'd1) begin
          state_d = S_IDLE;
        end
      end
      S_REL: begin
        if (clr_cnt_q == '0) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cpu_done_i) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // State-decoded outputs; in_ready is forced low while clr is asserted.
  always_comb begin
    in_ready_o    = 1'b0;
    test_normal_o = 1'b1;
    cpu_clr_o     = 1'b1;
    busy_o        = 1'b1;
    err_o         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready_o = ~clr_i;
        busy_o     = 1'b0;
      end
      S_ADDR, S_DATA: begin
        in_ready_o = ~clr_i;
      end
      S_REL: begin
        test_normal_o = 1'b0;
      end
      S_RUN: begin
        test_normal_o = 1'b0;
        cpu_clr_o     = 1'b0;
      end
      S_ERR: begin
        err_o = 1'b1;
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

  // Datapath next values: header/address capture, address advance, write staging.
  always_comb begin
    count_d      = count_q;
    addr_d       = addr_q;
    is_data_d    = is_data_q;
    clr_cnt_d    = clr_cnt_q;
    instr_we_d   = 1'b0;
    instr_addr_d = instr_addr_q;
    instr_data_d = instr_data_q;
    data_we_d    = 1'b0;
    data_addr_d  = data_addr_q;
    data_data_d  = data_data_q;
    run_done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          count_d   = in_data_i[13:0];
          is_data_d = (hdr_type == HDR_DATA);
          clr_cnt_d = CLR_LOAD;
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d = in_data_i;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (is_data_q) begin
            data_we_d   = 1'b1;
            data_addr_d = addr_q;
            data_data_d = in_data_i;
          end else begin
            instr_we_d   = 1'b1;
            instr_addr_d = addr_q;
            instr_data_d = in_data_i;
          end
          // 16-bit addition wraps FFFF to 0000 naturally.
          addr_d  = addr_q + 16'd1;
          count_d = count_q - 14'd1;
        end
      end
      S_REL: begin
        if (clr_cnt_q != '0) begin
          clr_cnt_d = clr_cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        run_done_d = cpu_done_i;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; clr clears any staged write so nothing partial reaches memory.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      count_q      <= '0;
      addr_q       <= '0;
      is_data_q    <= 1'b0;
      clr_cnt_q    <= '0;
      instr_we_q   <= 1'b0;
      instr_addr_q <= '0;
      instr_data_q <= '0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_data_q  <= '0;
      run_done_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      addr_q       <= addr_d;
      is_data_q    <= is_data_d;
      clr_cnt_q    <= clr_cnt_d;
      instr_we_q   <= instr_we_d;
      instr_addr_q <= instr_addr_d;
      instr_data_q <= instr_data_d;
      data_we_q    <= data_we_d;
      data_addr_q  <= data_addr_d;
      data_data_q  <= data_data_d;
      run_done_q   <= run_done_d;
    end
  end

  assign ext_instr_we_o   = instr_we_q;
  assign ext_instr_addr_o = instr_addr_q;
  assign ext_instr_data_o = instr_data_q;
  assign ext_data_we_o    = data_we_q;
  assign ext_data_addr_o  = data_addr_q;
  assign ext_data_data_o  = data_data_q;
  assign run_done_o       = run_done_q;

endmodule
